// File: rtl/sid_mix_sched.sv
// sid_mix_sched: time-multiplexed SID voice mixer.
// One signed multiplier is shared by the three voice/envelope pairs. An
// accepted CLKen snapshots all inputs, the three slots are issued to the
// multiplier on consecutive cycles, the scaled products are summed into an
// 18-bit accumulator and the saturated 16-bit result is presented on OUTPUT
// together with a one-cycle VALID strobe.
// Optional feature macro: SID_MIX_MUTE_EN (adds the MUTE[2:0] per-voice mute).

module sid_mix_sched #(
    parameter int MUL_LAT  = 1,
    parameter int HEADROOM = 2
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               CLKen,
    input  logic [11:0]        VOICE0,
    input  logic [11:0]        VOICE1,
    input  logic [11:0]        VOICE2,
    input  logic [7:0]         ENV0,
    input  logic [7:0]         ENV1,
    input  logic [7:0]         ENV2,
`ifdef SID_MIX_MUTE_EN
    input  logic [2:0]         MUTE,
`endif
    output logic signed [15:0] OUTPUT,
    output logic               VALID,
    output logic               BUSY,
    output logic               MISSED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]         slot;

    logic [11:0]        snap_voice0;
    logic [11:0]        snap_voice1;
    logic [11:0]        snap_voice2;
    logic [7:0]         snap_env0;
    logic [7:0]         snap_env1;
    logic [7:0]         snap_env2;
    logic [2:0]         mute_bits;
`ifdef SID_MIX_MUTE_EN
    logic [2:0]         snap_mute;
`endif

    logic [11:0]        sel_voice;
    logic [7:0]         sel_env;
    logic               sel_mute;
    logic signed [11:0] op_a_next;
    logic [7:0]         op_b_next;

    // Multiplier input register stage (maps onto the MAC input registers)
    logic signed [11:0] op_a;
    logic [7:0]         op_b;
    logic               op_vld;
    logic               op_last;

    logic signed [20:0] mul_a;
    logic signed [20:0] mul_b;
    logic signed [20:0] mul_p;

    // Product pipeline, MUL_LAT stages deep
    logic signed [20:0] prod_pipe [MUL_LAT];
    logic               vld_pipe  [MUL_LAT];
    logic               last_pipe [MUL_LAT];

    logic signed [20:0] prod_out;
    logic               prod_vld;
    logic               prod_last;

    logic signed [17:0] term;
    logic signed [17:0] acc;
    logic signed [15:0] acc_sat;

`ifdef SID_MIX_MUTE_EN
    assign mute_bits = snap_mute;
`else
    assign mute_bits = 3'b000;
`endif

    // Pick the snapshot operands for the slot currently being issued
    always_comb begin
        sel_voice = snap_voice0;
        sel_env   = snap_env0;
        sel_mute  = mute_bits[0];
        case (slot)
            2'd1: begin
                sel_voice = snap_voice1;
                sel_env   = snap_env1;
                sel_mute  = mute_bits[1];
            end
            2'd2: begin
                sel_voice = snap_voice2;
                sel_env   = snap_env2;
                sel_mute  = mute_bits[2];
            end
            default: ;
        endcase
        // Offset-binary to two's complement is just an MSB flip
        op_a_next = $signed({~sel_voice[11], sel_voice[10:0]});
        op_b_next = sel_env;
        if (sel_mute) begin
            op_a_next = 12'sd0;
            op_b_next = 8'd0;
        end
    end

    // Next-state logic for the issue/drain sequencer
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (CLKen) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (slot == 2'd2) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (prod_vld && prod_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Input snapshot and slot counter; the snapshot isolates the in-flight sample
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            slot        <= 2'd0;
            snap_voice0 <= 12'd0;
            snap_voice1 <= 12'd0;
            snap_voice2 <= 12'd0;
            snap_env0   <= 8'd0;
            snap_env1   <= 8'd0;
            snap_env2   <= 8'd0;
`ifdef SID_MIX_MUTE_EN
            snap_mute   <= 3'b000;
`endif
        end else begin
            if (state == S_IDLE && CLKen) begin
                slot        <= 2'd0;
                snap_voice0 <= VOICE0;
                snap_voice1 <= VOICE1;
                snap_voice2 <= VOICE2;
                snap_env0   <= ENV0;
                snap_env1   <= ENV1;
                snap_env2   <= ENV2;
`ifdef SID_MIX_MUTE_EN
                snap_mute   <= MUTE;
`endif
            end else if (state == S_ISSUE) begin
                slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            end
        end
    end

    // Multiplier operand register, tagged with a valid bit and last-slot flag
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            op_a    <= 12'sd0;
            op_b    <= 8'd0;
            op_vld  <= 1'b0;
            op_last <= 1'b0;
        end else begin
            op_a    <= op_a_next;
            op_b    <= op_b_next;
            op_vld  <= (state == S_ISSUE);
            op_last <= (state == S_ISSUE) && (slot == 2'd2);
        end
    end

    // Sign-extend the voice and zero-extend the envelope to the product width
    always_comb begin
        mul_a = {{9{op_a[11]}}, op_a};
        mul_b = $signed({13'd0, op_b});
        mul_p = mul_a * mul_b;
    end

    // Product pipeline; valid bits follow the data so the drain knows when the last product lands
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                prod_pipe[i] <= 21'sd0;
                vld_pipe[i]  <= 1'b0;
                last_pipe[i] <= 1'b0;
            end
        end else begin
            prod_pipe[0] <= mul_p;
            vld_pipe[0]  <= op_vld;
            last_pipe[0] <= op_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                prod_pipe[i] <= prod_pipe[i-1];
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign prod_out  = prod_pipe[MUL_LAT-1];
    assign prod_vld  = vld_pipe[MUL_LAT-1];
    assign prod_last = last_pipe[MUL_LAT-1];

    // Scale the product to 16 bits, apply headroom, and saturate the running sum
    always_comb begin
        term = 18'((prod_out >>> 4) >>> HEADROOM);
        if (acc > 18'sd32767) begin
            acc_sat = 16'sh7FFF;
        end else if (acc < -18'sd32768) begin
            acc_sat = 16'sh8000;
        end else begin
            acc_sat = acc[15:0];
        end
    end

    // Accumulator: cleared on an accepted request, adds each product as it emerges
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            acc <= 18'sd0;
        end else if (state == S_IDLE && CLKen) begin
            acc <= 18'sd0;
        end else if (prod_vld) begin
            acc <= acc + term;
        end
    end

    // Output register, VALID/BUSY handshake and dropped-request strobe
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            OUTPUT <= 16'sd0;
            VALID  <= 1'b0;
            BUSY   <= 1'b0;
            MISSED <= 1'b0;
        end else begin
            VALID  <= 1'b0;
            MISSED <= CLKen && (state != S_IDLE);
            if (state == S_IDLE && CLKen) begin
                BUSY <= 1'b1;
            end
            if (state == S_DONE) begin
                OUTPUT <= acc_sat;
                VALID  <= 1'b1;
                BUSY   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sid_mix_sched.sv
// tb_sid_mix_sched: directed bench for sid_mix_sched.
// Three instances share the stimulus: the default build (MUL_LAT=1,
// HEADROOM=2), a no-headroom build that can saturate, and a MUL_LAT=2 build.
// With SID_MIX_MUTE_EN defined the MUTE port is driven as well.

module tb_sid_mix_sched;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        CLKen;
    logic [11:0] VOICE0, VOICE1, VOICE2;
    logic [7:0]  ENV0, ENV1, ENV2;
`ifdef SID_MIX_MUTE_EN
    logic [2:0]  MUTE;
`endif

    logic signed [15:0] out_a, out_h, out_l;
    logic               vld_a, vld_h, vld_l;
    logic               busy_a, busy_h, busy_l;
    logic               miss_a, miss_h, miss_l;

    int testsRun    = 0;
    int testsFailed = 0;
    int firstV [3];
    int nV     [3];
    int nMiss;

    sid_mix_sched #(.MUL_LAT(1), .HEADROOM(2)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen),
        .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
        .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
`ifdef SID_MIX_MUTE_EN
        .MUTE(MUTE),
`endif
        .OUTPUT(out_a), .VALID(vld_a), .BUSY(busy_a), .MISSED(miss_a)
    );

    sid_mix_sched #(.MUL_LAT(1), .HEADROOM(0)) dut_h (
        .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen),
        .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
        .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
`ifdef SID_MIX_MUTE_EN
        .MUTE(MUTE),
`endif
        .OUTPUT(out_h), .VALID(vld_h), .BUSY(busy_h), .MISSED(miss_h)
    );

    sid_mix_sched #(.MUL_LAT(2), .HEADROOM(2)) dut_l (
        .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen),
        .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
        .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
`ifdef SID_MIX_MUTE_EN
        .MUTE(MUTE),
`endif
        .OUTPUT(out_l), .VALID(vld_l), .BUSY(busy_l), .MISSED(miss_l)
    );

    // 10 ns master clock
    always #5 CLK = ~CLK;

    // Count one comparison and report it if it differs
    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic setInputs(input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        VOICE0 = v0; VOICE1 = v1; VOICE2 = v2;
        ENV0   = e0; ENV1   = e1; ENV2   = e2;
    endtask

    // Load a vector and hold CLKen for exactly one sampling edge
    task automatic applyStimulus(input logic [11:0] v0, input logic [11:0] v1, input logic [11:0] v2,
                                 input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        setInputs(v0, v1, v2, e0, e1, e2);
        CLKen = 1'b1;
        @(posedge CLK);
        #1;
        CLKen = 1'b0;
    endtask

    // Watch a bounded number of cycles after the accepting edge; optionally
    // raise a second CLKen (with altered inputs) right after cycle extraAt
    task automatic waitSample(input int cycles, input int extraAt);
        logic [2:0] vbus;
        for (int k = 0; k < 3; k++) begin
            firstV[k] = -1;
            nV[k]     = 0;
        end
        nMiss = 0;
        for (int n = 1; n <= cycles; n++) begin
            @(posedge CLK);
            #1;
            vbus = {vld_l, vld_h, vld_a};
            for (int k = 0; k < 3; k++) begin
                if (vbus[k]) begin
                    nV[k]++;
                    if (firstV[k] < 0) firstV[k] = n;
                end
            end
            if (miss_a) nMiss++;
            if (n == extraAt) begin
                CLKen = 1'b1;
                setInputs(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF);
            end else begin
                CLKen = 1'b0;
            end
        end
    endtask

    // Standard single-sample checks across all three instances
    task automatic runSample(input string tag, input int expA, input int expH, input int expL, input int latL);
        waitSample(12, 0);
        checkOutput({tag, " latency"},    firstV[0], 6);
        checkOutput({tag, " valid count"}, nV[0], 1);
        checkOutput({tag, " output"},     out_a, expA);
        checkOutput({tag, " output h0"},  out_h, expH);
        checkOutput({tag, " output l2"},  out_l, expL);
        checkOutput({tag, " latency l2"}, firstV[2], latL);
        checkOutput({tag, " missed"},     nMiss, 0);
        checkOutput({tag, " busy after"}, busy_a, 0);
    endtask

    initial begin
        RSTn  = 1'b0;
        CLKen = 1'b0;
        setInputs(12'h800, 12'h800, 12'h800, 8'h00, 8'h00, 8'h00);
`ifdef SID_MIX_MUTE_EN
        MUTE = 3'b000;
`endif
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset output", out_a, 0);
        checkOutput("reset valid",  vld_a, 0);
        checkOutput("reset busy",   busy_a, 0);
        checkOutput("reset missed", miss_a, 0);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Voice 0 at full positive scale, other voices silent
        applyStimulus(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00);
        checkOutput("max pos busy", busy_a, 1);
        runSample("max pos", 8156, 32624, 8156, 7);

        // All voices at full negative scale
        applyStimulus(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF);
        runSample("min neg", -24480, -32768, -24480, 7);

        // All voices at full positive scale; saturates only without headroom
        applyStimulus(12'hFFF, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF);
        runSample("all pos", 24468, 32767, 24468, 7);

        // Mixed signs with floor rounding of a small negative product
        applyStimulus(12'hC00, 12'h400, 12'h7FF, 8'h80, 8'h10, 8'h03);
        runSample("mixed", 1791, 7167, 1791, 7);

        // Overrun during the drain: dropped, later inputs ignored
        applyStimulus(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00);
        waitSample(12, 3);
        checkOutput("overrun missed", nMiss, 1);
        checkOutput("overrun valid count", nV[0], 1);
        checkOutput("overrun output", out_a, 8156);
        checkOutput("overrun output h0", out_h, 32624);

        // Overrun landing in the DONE cycle is dropped too
        applyStimulus(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00);
        waitSample(12, 5);
        checkOutput("done overrun missed", nMiss, 1);
        checkOutput("done overrun valid count", nV[0], 1);
        checkOutput("done overrun output", out_a, 8156);

        // CLKen in the VALID cycle starts the next sample back to back
        applyStimulus(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00);
        waitSample(14, 6);
        checkOutput("b2b valid count", nV[0], 2);
        checkOutput("b2b missed", nMiss, 0);
        checkOutput("b2b output", out_a, -24480);

        // Reset in the middle of a sample aborts it
        applyStimulus(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("mid busy before reset", busy_a, 1);
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("mid reset output", out_a, 0);
        checkOutput("mid reset busy", busy_a, 0);
        RSTn = 1'b1;
        waitSample(10, 0);
        checkOutput("mid reset no valid", nV[0], 0);
        checkOutput("mid reset no valid l2", nV[2], 0);

        // Fresh sample after the reset
        applyStimulus(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF);
        runSample("post reset", -24480, -32768, -24480, 7);

`ifdef SID_MIX_MUTE_EN
        // Muting voice 0 silences the max-positive vector
        MUTE = 3'b001;
        applyStimulus(12'hFFF, 12'h800, 12'h800, 8'hFF, 8'h00, 8'h00);
        runSample("mute v0", 0, 0, 0, 7);
        // Muting voices 1 and 2 leaves one negative voice
        MUTE = 3'b110;
        applyStimulus(12'h000, 12'h000, 12'h000, 8'hFF, 8'hFF, 8'hFF);
        runSample("mute v12", -8160, -32640, -8160, 7);
        MUTE = 3'b000;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
